// File: rtl/rsfq_pulse_pkg.sv
// Shared definitions for the RSFQ cell pulse driver.
// Contents:
//   state_t        - transaction sequencer states
//   DEFAULT_*      - default pulse spacings in clk cycles
//   cnt_width()    - width of the shared spacing down-counter
package rsfq_pulse_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        A_SLOT   = 3'd1,
        WAIT_B   = 3'd2,
        B_SLOT   = 3'd3,
        WAIT_CLK = 3'd4,
        CLK_SLOT = 3'd5,
        CAPTURE  = 3'd6
    } state_t;

    localparam int DEFAULT_AB_GAP      = 2;
    localparam int DEFAULT_SETUP_CYC   = 2;
    localparam int DEFAULT_CAPTURE_CYC = 4;

    // The counter never holds more than (largest spacing - 1), so
    // $clog2 of the largest spacing is enough; keep at least one bit.
    function automatic int cnt_width(input int ab_gap, input int setup_cyc,
                                     input int capture_cyc);
        int m;
        m = ab_gap;
        if (setup_cyc > m)   m = setup_cyc;
        if (capture_cyc > m) m = capture_cyc;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

    localparam int DEFAULT_CNT_W =
        cnt_width(DEFAULT_AB_GAP, DEFAULT_SETUP_CYC, DEFAULT_CAPTURE_CYC);

endpackage

// File: rtl/rsfq_toggle_edge_det.sv
// Toggle-line edge detector for the cell's q response.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   q_in        - toggle-encoded line, already synchronous to clk
//   q_edge      - high for the one cycle in which q_in differs from its
//                 previous registered value (one SFQ pulse)
module rsfq_toggle_edge_det
    import rsfq_pulse_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic q_in,
    output logic q_edge
);

    logic q_prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_prev_reg <= 1'b0;
        end else begin
            q_prev_reg <= q_in;
        end
    end

    // Any difference from last cycle is one pulse on the toggle line.
    assign q_edge = q_in ^ q_prev_reg;

endmodule

// File: rtl/rsfq_cell_pulse_driver.sv
// Transmitter/decoder for a clocked two-input RSFQ cell using toggle
// encoding. Accepts one (a, b) pair per transaction, emits a, b and
// cell-clock toggles at fixed spacings, then decodes the q window into a
// parity result.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   in_valid, in_ready         - input handshake (ready while idle)
//   in_a, in_b                 - pulse requests, sampled at the handshake
//   a_out, b_out, sfq_clk_out  - toggle-encoded lines to the cell
//   q_in                       - toggle-encoded cell output
//   res_valid, res_bit         - one-cycle result strobe and q parity
//   err_spurious, err_multi    - sticky error flags
//   err_clr                    - synchronous clear of both flags
module rsfq_cell_pulse_driver
    import rsfq_pulse_pkg::*;
#(
    parameter int AB_GAP      = DEFAULT_AB_GAP,
    parameter int SETUP_CYC   = DEFAULT_SETUP_CYC,
    parameter int CAPTURE_CYC = DEFAULT_CAPTURE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_a,
    input  logic in_b,
    output logic a_out,
    output logic b_out,
    output logic sfq_clk_out,
    input  logic q_in,
    output logic res_valid,
    output logic res_bit,
    output logic err_spurious,
    output logic err_multi,
    input  logic err_clr
);

    localparam int CW = cnt_width(AB_GAP, SETUP_CYC, CAPTURE_CYC);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          lat_b_reg;
    logic          parity_reg;
    logic          seen_reg;
    logic          q_edge;
    logic          handshake;
    logic          in_window;
    logic          window_last;

    rsfq_toggle_edge_det u_edge_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .q_in   (q_in),
        .q_edge (q_edge)
    );

    assign in_ready    = (state_reg == IDLE);
    assign handshake   = in_valid && in_ready;
    assign in_window   = (state_reg == CAPTURE);
    assign window_last = in_window && (cnt_reg == '0);

    // Sequencer. One down-counter is shared by both waits and the capture
    // window. A wait of N cycles between slots is N-1 filler cycles, so
    // a spacing of 1 skips the wait state entirely.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (in_valid) state_next = A_SLOT;
            end
            A_SLOT: begin
                if (AB_GAP <= 1) begin
                    state_next = B_SLOT;
                end else begin
                    state_next = WAIT_B;
                    cnt_next   = CW'(AB_GAP - 2);
                end
            end
            WAIT_B: begin
                if (cnt_reg == '0) state_next = B_SLOT;
                else               cnt_next   = cnt_reg - CW'(1);
            end
            B_SLOT: begin
                if (SETUP_CYC <= 1) begin
                    state_next = CLK_SLOT;
                end else begin
                    state_next = WAIT_CLK;
                    cnt_next   = CW'(SETUP_CYC - 2);
                end
            end
            WAIT_CLK: begin
                if (cnt_reg == '0) state_next = CLK_SLOT;
                else               cnt_next   = cnt_reg - CW'(1);
            end
            CLK_SLOT: begin
                state_next = CAPTURE;
                cnt_next   = CW'(CAPTURE_CYC - 1);
            end
            CAPTURE: begin
                if (cnt_reg == '0) state_next = IDLE;
                else               cnt_next   = cnt_reg - CW'(1);
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            lat_b_reg    <= 1'b0;
            parity_reg   <= 1'b0;
            seen_reg     <= 1'b0;
            a_out        <= 1'b0;
            b_out        <= 1'b0;
            sfq_clk_out  <= 1'b0;
            res_valid    <= 1'b0;
            res_bit      <= 1'b0;
            err_spurious <= 1'b0;
            err_multi    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;

            // Pulses are launched on the edge that enters their slot, so
            // the toggle is visible during the slot cycle itself. The a
            // pulse therefore comes straight from the handshake.
            if (handshake) begin
                lat_b_reg <= in_b;
                if (in_a) a_out <= ~a_out;
            end
            if (state_next == B_SLOT && lat_b_reg) b_out <= ~b_out;
            if (state_next == CLK_SLOT) sfq_clk_out <= ~sfq_clk_out;

            if (state_reg == CLK_SLOT) begin
                parity_reg <= 1'b0;
                seen_reg   <= 1'b0;
            end else if (in_window && q_edge) begin
                parity_reg <= ~parity_reg;
                seen_reg   <= 1'b1;
            end

            // Result includes an edge arriving in the final window cycle.
            res_valid <= window_last;
            if (window_last) res_bit <= parity_reg ^ q_edge;

            // A new error in the same cycle as err_clr keeps the flag set.
            err_spurious <= (err_spurious && !err_clr) || (q_edge && !in_window);
            err_multi    <= (err_multi && !err_clr) || (q_edge && in_window && seen_reg);
        end
    end

endmodule
